// File: rtl/core_lsu_if.sv
// rtl/core_lsu_if.sv - valid/ready data-memory bus between core_lsu and the memory side
interface core_lsu_if #(parameter int XLEN = 64);
    logic            dbus_req_valid_o;
    logic            dbus_req_ready_i;
    logic [XLEN-1:0] dbus_addr_o;
    logic            dbus_we_o;
    logic [XLEN-1:0] dbus_wdata_o;
    logic [7:0]      dbus_wstrb_o;
    logic            dbus_rsp_valid_i;
    logic [XLEN-1:0] dbus_rdata_i;

    modport master (
        output dbus_req_valid_o, dbus_addr_o, dbus_we_o, dbus_wdata_o, dbus_wstrb_o,
        input  dbus_req_ready_i, dbus_rsp_valid_i, dbus_rdata_i
    );

    modport slave (
        input  dbus_req_valid_o, dbus_addr_o, dbus_we_o, dbus_wdata_o, dbus_wstrb_o,
        output dbus_req_ready_i, dbus_rsp_valid_i, dbus_rdata_i
    );
endinterface

// File: rtl/core_lsu.sv
// rtl/core_lsu.sv - MEM-stage load/store unit driving a valid/ready data bus
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module core_lsu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] mem_data_o,
    output logic            stall_o,
    output logic            misalign_o,
    core_lsu_if.master      dbus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t          state, state_next;
    logic            access, trap, start;
    logic [1:0]      size, size_q;
    logic [2:0]      size_mask, lane, lane_q;
    logic            uns_q;
    logic [7:0]      strb_base;
    logic [XLEN-1:0] rdata_shift, load_ext;

    assign access = mem_read_i | mem_write_i;
    assign size   = funct3_i[1:0];

    always_comb begin
        size_mask = 3'b000;
        strb_base = 8'h01;
        case (size)
            2'd1: begin size_mask = 3'b001; strb_base = 8'h03; end
            2'd2: begin size_mask = 3'b011; strb_base = 8'h0F; end
            2'd3: begin size_mask = 3'b111; strb_base = 8'hFF; end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = access & (|(addr_i[2:0] & size_mask));
`else
    assign trap = 1'b0;
`endif

    // Clearing the sub-size bits forces alignment when the trap is disabled
    // and is a no-op for any access that is allowed to proceed when it is.
    assign lane  = addr_i[2:0] & ~size_mask;
    assign start = (state == S_IDLE) & access & ~trap;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next            = state;
        stall_o               = 1'b0;
        misalign_o            = 1'b0;
        dbus.dbus_req_valid_o = 1'b0;
        case (state)
            S_IDLE: begin
                stall_o    = start;
                misalign_o = trap;
                if (start) state_next = S_REQ;
            end
            S_REQ: begin
                stall_o               = 1'b1;
                dbus.dbus_req_valid_o = 1'b1;
                if (dbus.dbus_req_ready_i) state_next = S_WAIT;
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (dbus.dbus_rsp_valid_i) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbus.dbus_addr_o  <= '0;
            dbus.dbus_we_o    <= 1'b0;
            dbus.dbus_wdata_o <= '0;
            dbus.dbus_wstrb_o <= '0;
            size_q            <= '0;
            uns_q             <= 1'b0;
            lane_q            <= '0;
        end else if (start) begin
            dbus.dbus_addr_o  <= {addr_i[XLEN-1:3], 3'b000};
            dbus.dbus_we_o    <= mem_write_i;
            dbus.dbus_wdata_o <= wdata_i << {lane, 3'b000};
            dbus.dbus_wstrb_o <= strb_base << lane;
            size_q            <= size;
            uns_q             <= funct3_i[2];
            lane_q            <= lane;
        end
    end

    assign rdata_shift = dbus.dbus_rdata_i >> {lane_q, 3'b000};

    always_comb begin
        load_ext = rdata_shift;
        case (size_q)
            2'd0: load_ext = {{(XLEN-8){~uns_q & rdata_shift[7]}}, rdata_shift[7:0]};
            2'd1: load_ext = {{(XLEN-16){~uns_q & rdata_shift[15]}}, rdata_shift[15:0]};
            2'd2: load_ext = {{(XLEN-32){~uns_q & rdata_shift[31]}}, rdata_shift[31:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_data_o <= '0;
        end else if ((state == S_WAIT) && dbus.dbus_rsp_valid_i && !dbus.dbus_we_o) begin
            mem_data_o <= load_ext;
        end
    end
endmodule
